// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, the bubble instruction and the default datapath widths.
package fetch_pkg;

  localparam int          FETCH_PC_W   = 16;
  localparam int          FETCH_INSN_W = 16;
  localparam logic [15:0] FETCH_NOP    = 16'h0800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word (pc + insn) that arrived
// while decode was stalled with the IF/ID slot already occupied.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int PC_W   = FETCH_PC_W,
  parameter int INSN_W = FETCH_INSN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INSN_W-1:0] i_insn,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [INSN_W-1:0] o_insn
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [INSN_W-1:0] r_insn;

  // Flush (reset or redirect) wins over load; drain empties after hand-off.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_insn  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_insn  <= i_insn;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_insn  = r_insn;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, runs the req/ack
// handshake to instruction memory, applies redirects and feeds the IF/ID
// slot. A one-entry skid buffer absorbs a word that lands during a stall.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                PC_W     = FETCH_PC_W,
  parameter int                INSN_W   = FETCH_INSN_W,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INSN_W-1:0] NOP      = INSN_W'(FETCH_NOP)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INSN_W-1:0] i_imem_rdata,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_if_valid,
  output logic [PC_W-1:0]   o_if_pc,
  output logic [INSN_W-1:0] o_if_insn
);

  fetch_state_t      r_state;
  logic              r_req;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_imem_addr;
  logic              r_if_valid;
  logic [PC_W-1:0]   r_if_pc;
  logic [INSN_W-1:0] r_if_insn;

  logic              w_consume;
  logic [PC_W-1:0]   w_addr_inc;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic              w_skid_valid;
  logic [PC_W-1:0]   w_skid_pc;
  logic [INSN_W-1:0] w_skid_insn;

  // Decode takes the slot on any edge where it is live and not stalled.
  assign w_consume  = r_if_valid & ~i_stall;
  assign w_addr_inc = r_imem_addr + 1'b1;

  // The skid captures an acked word only when the slot is full and held.
  assign w_skid_load  = ~i_rst & ~i_redirect_valid & (r_state == REQ) &
                        i_imem_ack & r_if_valid & i_stall;
  assign w_skid_drain = ~i_rst & ~i_redirect_valid & (r_state == HOLD) & w_consume;

  fetch_skid #(
    .PC_W   (PC_W),
    .INSN_W (INSN_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (i_redirect_valid),
    .i_pc    (r_imem_addr),
    .i_insn  (i_imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_insn  (w_skid_insn)
  );

  // Fetch FSM, PC and IF/ID slot; redirect outranks ack and stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_insn   <= NOP;
    end else if (i_redirect_valid) begin
      r_if_valid <= 1'b0;
      r_if_insn  <= NOP;
      r_pc       <= i_redirect_pc;
      r_req      <= 1'b1;
      if (r_req && !i_imem_ack) begin
        r_state <= DRAIN;
      end else begin
        r_imem_addr <= i_redirect_pc;
        r_state     <= REQ;
      end
    end else begin
      if (w_consume) begin
        r_if_valid <= 1'b0;
        r_if_insn  <= NOP;
      end
      case (r_state)
        IDLE: begin
          r_state     <= REQ;
          r_req       <= 1'b1;
          r_imem_addr <= r_pc;
        end
        REQ: begin
          if (i_imem_ack) begin
            r_pc <= w_addr_inc;
            if (!r_if_valid || !i_stall) begin
              r_if_valid  <= 1'b1;
              r_if_pc     <= r_imem_addr;
              r_if_insn   <= i_imem_rdata;
              r_imem_addr <= w_addr_inc;
            end else begin
              r_state <= HOLD;
              r_req   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (w_consume && w_skid_valid) begin
            r_if_valid  <= 1'b1;
            r_if_pc     <= w_skid_pc;
            r_if_insn   <= w_skid_insn;
            r_imem_addr <= r_pc;
            r_state     <= REQ;
            r_req       <= 1'b1;
          end
        end
        DRAIN: begin
          if (i_imem_ack) begin
            r_imem_addr <= r_pc;
            r_state     <= REQ;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_imem_addr;
  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_insn   = r_if_insn;

endmodule
